seg_read_buffer: RTL
====================

# seg_read_buffer

Multi-line segment buffer for the PageRank datapath. It accepts wide memory lines (FULL_WIDTH bits), each tagged with an element range [base, bounds), and queues up to 2^LOG_DEPTH lines. It emits only the in-range WIDTH-bit elements, one per cycle, over a valid/ready stream. It sits between the memory-read response path and the edge/rank consumers, and replaces the single-ported rdreq/empty-style buffer with a handshake-based, range-clamped, parametrised version.

## Interface
- FULL_WIDTH, 512: line width in bits.
- WIDTH, 64: element width in bits; ELEMS = FULL_WIDTH/WIDTH must be a power of two ≥2.
- LOG_DEPTH, 4: line FIFO depth is 2^LOG_DEPTH lines.
- IDX_W, 8: width of base/bounds/index fields; ELEMS ≤ 2^IDX_W.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- wr_valid  in  1  line offered.
- wr_ready  out  1  line accepted when wr_valid && wr_ready.
- wr_data  in  FULL_WIDTH  line payload.
- wr_base  in  IDX_W  first element index (inclusive).
- wr_bounds  in  IDX_W  end element index (exclusive).
- rd_valid  out  1  element available.
- rd_ready  in  1  consumer takes element.
- rd_data  out  WIDTH  current element; 0 when rd_valid=0.
- rd_idx  out  IDX_W  index of current element in its line; 0 when rd_valid=0.
- rd_last  out  1  current element is last of its line; 0 when rd_valid=0.
- lines  out  LOG_DEPTH+1  stored line count.
- dropped  out  16  saturating count of zero-element lines discarded.

## Operation
- Clamp on write: b = wr_base; e = min(wr_bounds, ELEMS); n = (e > b) ? e − b : 0 (compare unsigned, IDX_W bits).
- n = 0 (includes b ≥ ELEMS or bounds ≤ base): line is accepted (handshake completes), not stored; dropped increments, saturating at 0xFFFF.
- n > 0: line, b, and e are written at wrline; wrline increments and wraps modulo 2^LOG_DEPTH.
- Element k of a line = wr_data[FULL_WIDTH−1−k·WIDTH −: WIDTH] (element 0 is the most significant slice).
- Head state: rdline, rdptr. When a line becomes head, rdptr loads its stored b.
- Pop (rd_valid && rd_ready): if rdptr = e−1 (rd_last), rdline increments (wraps) and lines decrements; otherwise rdptr increments.
- rd_valid = (lines ≠ 0); wr_ready = (lines ≠ 2^LOG_DEPTH).
- Simultaneous stored write and last-element pop: lines unchanged, both pointers advance.
- Write into an empty buffer: the new line is head on the next cycle, and rdptr = its b.
- rst clears lines, rdline, wrline, rdptr, and dropped. Storage is not reset. A mid-stream reset discards all queued lines, including a partially consumed head line.

## Timing
- Reset values: wr_ready=1, rd_valid=0, rd_data=0, rd_idx=0, rd_last=0, lines=0, dropped=0.
- Write-to-read latency: 1 cycle. A line accepted at edge t gives rd_valid=1 in the cycle after t.
- rd_data, rd_idx, and rd_last come combinationally from registered state and storage. There is no read-side register stage.
- Throughput: 1 element/cycle sustained, with no bubble between lines.
- wr_ready depends only on lines, not on rd_ready. When full, a write is refused even if the head line completes in the same cycle.
- rd_data holds stable while rd_valid && !rd_ready.

## Configuration
- SEG_READ_BUFFER_LSB_FIRST_EN defined: element k = wr_data[k·WIDTH +: WIDTH] (element 0 is the least significant slice).
- Not defined: MSB-first ordering, as stated in Operation.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then write one line with ELEMS=8, base=2, bounds=5, rd_ready=1 -> elements 2, 3, 4 on consecutive cycles starting 1 cycle after the write; rd_idx=2,3,4; rd_last only on idx 4; lines returns to 0.
- Write bounds=20 with base=6 -> clamped; elements 6, 7 emitted; rd_last on 7.
- Write base=9, then base=4 with bounds=4 -> both accepted, nothing emitted, dropped=2, lines=0.
- Hold rd_ready=0 and write 17 lines (LOG_DEPTH=4) -> wr_ready=0 after the 16th, lines=16; the 17th is accepted only after the head line fully drains.
- Two back-to-back full lines (base 0, bounds 8), continuous rd_ready -> 16 elements with no gap; on the cycle a write coincides with a last pop, lines is unchanged.
- Assert rst after 3 of 8 elements -> next cycle rd_valid=0, lines=0, dropped=0; a new line then streams from its own base.

Source files
------------

// File: rtl/seg_read_buffer.sv
// Range-clamped line FIFO that streams the in-range elements of each queued line over valid/ready.
// Define SEG_READ_BUFFER_LSB_FIRST_EN to make element 0 the least significant slice of a line.
module seg_read_buffer #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int LOG_DEPTH  = 4,
    parameter int IDX_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [FULL_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      wr_base,
    input  logic [IDX_W-1:0]      wr_bounds,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_last,
    output logic [LOG_DEPTH:0]    lines,
    output logic [15:0]           dropped
);
    localparam int ELEMS = FULL_WIDTH / WIDTH;
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int EW    = $clog2(ELEMS);
    localparam logic [IDX_W:0]     ELEMS_X = (IDX_W+1)'(ELEMS);
    localparam logic [LOG_DEPTH:0] FULL_X  = (LOG_DEPTH+1)'(DEPTH);

    typedef logic [LOG_DEPTH-1:0] ptr_t;

    logic [FULL_WIDTH-1:0] data_mem [DEPTH];
    logic [IDX_W-1:0]      base_mem [DEPTH];
    logic [IDX_W-1:0]      last_mem [DEPTH];

    ptr_t             wrline_q, wrline_d;
    ptr_t             rdline_q, rdline_d;
    logic [IDX_W-1:0] rdptr_q, rdptr_d;
    logic [LOG_DEPTH:0] lines_q, lines_d;
    logic [15:0]      dropped_q, dropped_d;

    logic [IDX_W:0]   end_clamp;
    logic [IDX_W-1:0] wr_last_idx;
    logic             has_elems, accept, store, drop;
    logic             head_last, pop, pop_last;
    ptr_t             next_head;
    logic [WIDTH-1:0] head_elems [ELEMS];

    // Extra bit keeps the clamp exact even when ELEMS equals 2^IDX_W.
    assign end_clamp   = ({1'b0, wr_bounds} > ELEMS_X) ? ELEMS_X : {1'b0, wr_bounds};
    assign has_elems   = end_clamp > {1'b0, wr_base};
    assign wr_last_idx = IDX_W'(end_clamp - 1'b1);

    assign wr_ready  = (lines_q != FULL_X);
    assign accept    = wr_valid && wr_ready;
    assign store     = accept && has_elems;
    assign drop      = accept && !has_elems;

    assign rd_valid  = (lines_q != '0);
    assign head_last = (rdptr_q == last_mem[rdline_q]);
    assign pop       = rd_valid && rd_ready;
    assign pop_last  = pop && head_last;
    assign next_head = rdline_q + 1'b1;

    always_comb begin
        for (int k = 0; k < ELEMS; k++) begin
`ifdef SEG_READ_BUFFER_LSB_FIRST_EN
            head_elems[k] = data_mem[rdline_q][k*WIDTH +: WIDTH];
`else
            head_elems[k] = data_mem[rdline_q][FULL_WIDTH-1-k*WIDTH -: WIDTH];
`endif
        end
    end

    assign rd_data = rd_valid ? head_elems[rdptr_q[EW-1:0]] : '0;
    assign rd_idx  = rd_valid ? rdptr_q : '0;
    assign rd_last = rd_valid && head_last;
    assign lines   = lines_q;
    assign dropped = dropped_q;

    always_comb begin
        wrline_d  = wrline_q;
        rdline_d  = rdline_q;
        rdptr_d   = rdptr_q;
        lines_d   = lines_q;
        dropped_d = dropped_q;

        if (store) wrline_d = wrline_q + 1'b1;
        if (drop && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;

        case ({store, pop_last})
            2'b10:   lines_d = lines_q + 1'b1;
            2'b01:   lines_d = lines_q - 1'b1;
            default: lines_d = lines_q;
        endcase

        if (pop_last) begin
            rdline_d = next_head;
            // With one line queued, the only possible next head is the one being written now.
            rdptr_d  = (lines_q == (LOG_DEPTH+1)'(1)) ? wr_base : base_mem[next_head];
        end else if (pop) begin
            rdptr_d = rdptr_q + 1'b1;
        end else if (!rd_valid && store) begin
            rdptr_d = wr_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrline_q  <= '0;
            rdline_q  <= '0;
            rdptr_q   <= '0;
            lines_q   <= '0;
            dropped_q <= '0;
        end else begin
            wrline_q  <= wrline_d;
            rdline_q  <= rdline_d;
            rdptr_q   <= rdptr_d;
            lines_q   <= lines_d;
            dropped_q <= dropped_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[wrline_q] <= wr_data;
            base_mem[wrline_q] <= wr_base;
            last_mem[wrline_q] <= wr_last_idx;
        end
    end
endmodule
